mega_jsoc_oci_ram_arbiter: RTL and testbench

Sequences and shares the single-port OCI debug RAM between two requesters: the JTAG debug path (sysclk-side command strobes) and the CPU monitor path. Each request is a one-cycle strobe with payload. The block captures it, arbitrates, drives one RAM access and returns a one-cycle ack, plus read data for reads. It sits between the JTAG debug module's sysclk-side command decode, the CPU monitor logic and the OCI RAM macro.

---
 rtl/mega_jsoc_oci_ram_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mega_jsoc_oci_ram_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mega_jsoc_oci_ram_arbiter.sv
// Arbiter sharing the single-port OCI debug RAM between the JTAG and CPU monitor paths.
// Optional performance counters are enabled with `define OCI_ARB_PERF_EN.
module mega_jsoc_oci_ram_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              jtag_req,
   input  logic              jtag_wr,
   input  logic [ADDR_W-1:0] jtag_addr,
   input  logic [DATA_W-1:0] jtag_wdata,
   output logic              jtag_ack,
   output logic [DATA_W-1:0] jtag_rdata,
   input  logic              cpu_req,
   input  logic              cpu_wr,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              debugack,
   output logic              ram_cs,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy,
   output logic              overrun
`ifdef OCI_ARB_PERF_EN
   ,
   input  logic              perf_clr,
   output logic [15:0]       perf_jtag_cnt,
   output logic [15:0]       perf_cpu_cnt,
   output logic [15:0]       perf_conflict_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

   localparam logic [1:0] RD_LAST = 2'(RD_LAT - 1);

   state_t              state, state_nxt;
   logic                jtag_pend, cpu_pend;
   logic                j_wr, c_wr;
   logic [ADDR_W-1:0]   j_addr, c_addr;
   logic [DATA_W-1:0]   j_wdata, c_wdata;
   logic                gnt_cpu;   // last/current granted source, doubles as round-robin pointer
   logic                cur_wr;
   logic [1:0]          wcnt;
   logic                grant, sel_cpu, rd_last;
   logic                j_busy, c_busy;

   assign grant   = (state == IDLE) && (jtag_pend || cpu_pend);
   assign sel_cpu = cpu_pend && (!jtag_pend || (!debugack && !gnt_cpu));
   assign j_busy  = jtag_pend || ((state != IDLE) && !gnt_cpu);
   assign c_busy  = cpu_pend  || ((state != IDLE) &&  gnt_cpu);
   assign rd_last = (state == WAIT_RD) && (wcnt == RD_LAST);

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant)   state_nxt = ISSUE;
         ISSUE:   state_nxt = cur_wr ? RESP : WAIT_RD;
         WAIT_RD: if (rd_last) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      ram_cs   = (state == ISSUE);
      ram_we   = (state == ISSUE) && cur_wr;
      jtag_ack = (state == RESP) && !gnt_cpu;
      cpu_ack  = (state == RESP) &&  gnt_cpu;
      busy     = (state != IDLE) || jtag_pend || cpu_pend;
   end

   // request capture; a strobe can never coincide with the grant of its own source
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         jtag_pend <= 1'b0;
         cpu_pend  <= 1'b0;
         j_wr      <= 1'b0;
         j_addr    <= '0;
         j_wdata   <= '0;
         c_wr      <= 1'b0;
         c_addr    <= '0;
         c_wdata   <= '0;
         overrun   <= 1'b0;
      end else begin
         if (jtag_req && !j_busy) begin
            jtag_pend <= 1'b1;
            j_wr      <= jtag_wr;
            j_addr    <= jtag_addr;
            j_wdata   <= jtag_wdata;
         end else if (grant && !sel_cpu) begin
            jtag_pend <= 1'b0;
         end
         if (cpu_req && !c_busy) begin
            cpu_pend <= 1'b1;
            c_wr     <= cpu_wr;
            c_addr   <= cpu_addr;
            c_wdata  <= cpu_wdata;
         end else if (grant && sel_cpu) begin
            cpu_pend <= 1'b0;
         end
         if ((jtag_req && j_busy) || (cpu_req && c_busy)) overrun <= 1'b1;
      end
   end

   // grant bookkeeping and RAM address/data, which hold between accesses
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gnt_cpu   <= 1'b1;
         cur_wr    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
      end else if (grant) begin
         gnt_cpu   <= sel_cpu;
         cur_wr    <= sel_cpu ? c_wr    : j_wr;
         ram_addr  <= sel_cpu ? c_addr  : j_addr;
         ram_wdata <= sel_cpu ? c_wdata : j_wdata;
      end
   end

   // read latency counter and read data return
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wcnt       <= '0;
         jtag_rdata <= '0;
         cpu_rdata  <= '0;
      end else begin
         wcnt <= (state == WAIT_RD) ? wcnt + 2'd1 : 2'd0;
         if (rd_last) begin
            if (gnt_cpu) cpu_rdata  <= ram_rdata;
            else         jtag_rdata <= ram_rdata;
         end
      end
   end

`ifdef OCI_ARB_PERF_EN
   logic conflict;
   assign conflict = (state == IDLE) && jtag_pend && cpu_pend;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_jtag_cnt     <= '0;
         perf_cpu_cnt      <= '0;
         perf_conflict_cnt <= '0;
      end else if (perf_clr) begin
         perf_jtag_cnt     <= '0;
         perf_cpu_cnt      <= '0;
         perf_conflict_cnt <= '0;
      end else begin
         if (grant && !sel_cpu && perf_jtag_cnt != 16'hFFFF) perf_jtag_cnt <= perf_jtag_cnt + 16'd1;
         if (grant &&  sel_cpu && perf_cpu_cnt  != 16'hFFFF) perf_cpu_cnt  <= perf_cpu_cnt  + 16'd1;
         if (conflict && perf_conflict_cnt != 16'hFFFF) perf_conflict_cnt <= perf_conflict_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mega_jsoc_oci_ram_arbiter.sv
// Bench for mega_jsoc_oci_ram_arbiter: directed scenarios then random traffic against a
// transaction-timing reference model; a behavioural RAM answers the DUT's accesses.
module tb_mega_jsoc_oci_ram_arbiter;
   localparam int RD_LAT = 2;
   localparam int MAXC   = 4096;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        jtag_req = 0, jtag_wr = 0, cpu_req = 0, cpu_wr = 0, debugack = 0;
   logic [7:0]  jtag_addr = 0, cpu_addr = 0;
   logic [31:0] jtag_wdata = 0, cpu_wdata = 0;
   logic        jtag_ack, cpu_ack, ram_cs, ram_we, busy, overrun;
   logic [31:0] jtag_rdata, cpu_rdata, ram_wdata, ram_rdata;
   logic [7:0]  ram_addr;
`ifdef OCI_ARB_PERF_EN
   logic        perf_clr = 0;
   logic [15:0] perf_jtag_cnt, perf_cpu_cnt, perf_conflict_cnt;
   int          mp_j, mp_c, mp_x;
   bit          clr_next;
`endif

   always #5 clk = ~clk;

   mega_jsoc_oci_ram_arbiter #(.ADDR_W(8), .DATA_W(32), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .reset(reset),
      .jtag_req(jtag_req), .jtag_wr(jtag_wr), .jtag_addr(jtag_addr), .jtag_wdata(jtag_wdata),
      .jtag_ack(jtag_ack), .jtag_rdata(jtag_rdata),
      .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .debugack(debugack),
      .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .busy(busy), .overrun(overrun)
`ifdef OCI_ARB_PERF_EN
      , .perf_clr(perf_clr), .perf_jtag_cnt(perf_jtag_cnt), .perf_cpu_cnt(perf_cpu_cnt),
      .perf_conflict_cnt(perf_conflict_cnt)
`endif
   );

   // behavioural RAM: data valid exactly RD_LAT cycles after the cs cycle, noise otherwise
   logic [31:0] tmem [256];
   logic [31:0] rd_pipe [1:RD_LAT];
   assign ram_rdata = rd_pipe[RD_LAT];
   always @(posedge clk) begin
      if (ram_cs && ram_we) tmem[ram_addr] <= ram_wdata;
      rd_pipe[1] <= (ram_cs && !ram_we) ? tmem[ram_addr] : $urandom;
      for (int k = 2; k <= RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
   end

   // reference model: per-cycle expectation tables filled at grant time
   int          n_tot = 0, n_bad = 0, cyc = 0;
   bit          e_cs [MAXC], e_we [MAXC], e_jack [MAXC], e_cack [MAXC], e_rd [MAXC];
   logic [7:0]  e_addr [MAXC];
   logic [31:0] e_wd [MAXC], e_rdv [MAXC];
   logic [31:0] rmem [256];
   bit          m_jp, m_cp, m_jw, m_cw, m_fl, fl_cpu, m_last_cpu, m_ov;
   logic [7:0]  m_ja, m_ca;
   logic [31:0] m_jd, m_cd, m_jrd, m_crd;
   int          fl_g, fl_a;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_clear();
      m_jp = 0; m_cp = 0; m_fl = 0; m_last_cpu = 1; m_ov = 0; m_jrd = 0; m_crd = 0;
      for (int i = cyc; i < cyc + 16 && i < MAXC; i++) begin
         e_cs[i] = 0; e_jack[i] = 0; e_cack[i] = 0; e_rd[i] = 0;
      end
`ifdef OCI_ARB_PERF_EN
      mp_j = 0; mp_c = 0; mp_x = 0;
`endif
   endtask

   // one cycle: check outputs, advance the model, drive this cycle's inputs
   task automatic step(input bit jr, input bit jw, input logic [7:0] ja, input logic [31:0] jd,
                       input bit cr, input bit cw, input logic [7:0] ca, input logic [31:0] cd,
                       input bit dbg);
      bit pj, pc, jinf, cinf, sel, wr, exp_busy;
      logic [7:0] a;
      logic [31:0] d;
      if (e_jack[cyc] && e_rd[cyc]) m_jrd = e_rdv[cyc];
      if (e_cack[cyc] && e_rd[cyc]) m_crd = e_rdv[cyc];
      exp_busy = m_jp || m_cp || (m_fl && cyc > fl_g && cyc <= fl_a);
      chk("ram_cs", 32'(ram_cs), 32'(e_cs[cyc]));
      if (e_cs[cyc]) begin
         chk("ram_we", 32'(ram_we), 32'(e_we[cyc]));
         chk("ram_addr", 32'(ram_addr), 32'(e_addr[cyc]));
         if (e_we[cyc]) chk("ram_wdata", ram_wdata, e_wd[cyc]);
      end
      chk("jtag_ack", 32'(jtag_ack), 32'(e_jack[cyc]));
      chk("cpu_ack", 32'(cpu_ack), 32'(e_cack[cyc]));
      chk("jtag_rdata", jtag_rdata, m_jrd);
      chk("cpu_rdata", cpu_rdata, m_crd);
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("overrun", 32'(overrun), 32'(m_ov));
`ifdef OCI_ARB_PERF_EN
      chk("perf_jtag", 32'(perf_jtag_cnt), 32'(mp_j));
      chk("perf_cpu", 32'(perf_cpu_cnt), 32'(mp_c));
      chk("perf_conf", 32'(perf_conflict_cnt), 32'(mp_x));
`endif
      pj = m_jp; pc = m_cp;
      jinf = m_fl && !fl_cpu && cyc > fl_g && cyc <= fl_a;
      cinf = m_fl &&  fl_cpu && cyc > fl_g && cyc <= fl_a;
      if ((pj || pc) && !(m_fl && cyc <= fl_a)) begin
         sel = pc && (!pj || (!dbg && !m_last_cpu));
         wr = sel ? m_cw : m_jw;
         a  = sel ? m_ca : m_ja;
         d  = sel ? m_cd : m_jd;
         fl_g = cyc; fl_a = cyc + 2 + (wr ? 0 : RD_LAT);
         m_fl = 1; fl_cpu = sel; m_last_cpu = sel;
         e_cs[cyc+1] = 1; e_we[cyc+1] = wr; e_addr[cyc+1] = a; e_wd[cyc+1] = d;
         e_rd[fl_a] = !wr;
         if (wr) rmem[a] = d;
         else    e_rdv[fl_a] = rmem[a];
         if (sel) begin e_cack[fl_a] = 1; m_cp = 0; end
         else     begin e_jack[fl_a] = 1; m_jp = 0; end
`ifdef OCI_ARB_PERF_EN
         if (!clr_next) begin
            if (sel) mp_c++; else mp_j++;
            if (pj && pc) mp_x++;
         end
`endif
      end
`ifdef OCI_ARB_PERF_EN
      if (clr_next) begin mp_j = 0; mp_c = 0; mp_x = 0; end
      perf_clr = clr_next;
`endif
      if (jr) begin
         if (pj || jinf) m_ov = 1;
         else begin m_jp = 1; m_jw = jw; m_ja = ja; m_jd = jd; end
      end
      if (cr) begin
         if (pc || cinf) m_ov = 1;
         else begin m_cp = 1; m_cw = cw; m_ca = ca; m_cd = cd; end
      end
      jtag_req = jr; jtag_wr = jw; jtag_addr = ja; jtag_wdata = jd;
      cpu_req = cr; cpu_wr = cw; cpu_addr = ca; cpu_wdata = cd;
      debugack = dbg;
      @(negedge clk);
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, debugack);
   endtask

   // asynchronous reset asserted mid-cycle; outputs must clear before any clock edge
   task automatic do_reset();
      #2 reset = 1'b1;
      #1;
      model_clear();
      chk("rst_ram_cs", 32'(ram_cs), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_jack", 32'(jtag_ack), 0);
      chk("rst_cack", 32'(cpu_ack), 0);
      chk("rst_ovr", 32'(overrun), 0);
      jtag_req = 0; cpu_req = 0;
      @(negedge clk);
      reset = 1'b0;
      cyc++;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin tmem[i] = 0; rmem[i] = 0; end
      for (int k = 1; k <= RD_LAT; k++) rd_pipe[k] = 0;
`ifdef OCI_ARB_PERF_EN
      clr_next = 0;
`endif
      model_clear();
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // write then read back at the documented latencies
      idle(2);
      step(1, 1, 8'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0);
      idle(5);
      step(0, 0, 0, 0, 1, 0, 8'h10, 0, 0);
      idle(7);
      chk("rd_back", cpu_rdata, 32'hDEADBEEF);

      // ties: fresh reset -> JTAG, then CPU by round-robin, then JTAG under debugack
      do_reset();
      step(1, 1, 8'h20, 32'h1111, 1, 1, 8'h21, 32'h2222, 0);
      idle(10);
      step(1, 0, 8'h21, 0, 1, 0, 8'h20, 0, 0);
      idle(14);
      step(1, 1, 8'h22, 32'h3333, 1, 1, 8'h23, 32'h4444, 1);
      idle(10);

      // second JTAG strobe while its access is in flight
      step(1, 0, 8'h22, 0, 0, 0, 0, 0, 0);
      idle(1);
      step(1, 1, 8'h22, 32'hBAD0, 0, 0, 0, 0, 0);
      idle(8);
      chk("overrun_set", 32'(overrun), 1);

      // reset during WAIT_RD; a queued JTAG request must be dropped
      step(0, 0, 0, 0, 1, 0, 8'h21, 0, 0);
      idle(1);
      step(1, 0, 8'h20, 0, 0, 0, 0, 0, 0);
      do_reset();
      idle(8);

`ifdef OCI_ARB_PERF_EN
      for (int p = 0; p < 3; p++) begin
         step(1, 1, 8'h30, 32'(p), 1, 1, 8'h31, 32'(p), 0);
         idle(10);
      end
      chk("perf_j3", 32'(perf_jtag_cnt), 3);
      chk("perf_c3", 32'(perf_cpu_cnt), 3);
      chk("perf_x3", 32'(perf_conflict_cnt >= 16'd3), 1);
      clr_next = 1;
      idle(1);
      clr_next = 0;
      idle(1);
`endif

      // random traffic over a small address window so reads hit earlier writes
      for (int i = 0; i < 1500; i++) begin
`ifdef OCI_ARB_PERF_EN
         clr_next = ($urandom_range(0, 199) == 0);
`endif
         step(($urandom_range(0, 5) == 0), 1'($urandom), 8'($urandom_range(0, 15)), $urandom,
              ($urandom_range(0, 5) == 0), 1'($urandom), 8'($urandom_range(0, 15)), $urandom,
              ($urandom_range(0, 3) == 0));
      end
`ifdef OCI_ARB_PERF_EN
      clr_next = 0;
`endif
      idle(10);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end
endmodule
